// File: rtl/icache_if.sv
// Pipeline fetch port and memory-controller read port of the instruction cache.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-block, read-only instruction cache with a
// single-word miss fetch from the memory controller.
module icache #(
  parameter int NSETS = 16,
  parameter int IDX_W = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  icache_if.slave     bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state, next_state;
  logic              valid [NSETS];
  logic [TAG_W-1:0]  tags  [NSETS];
  logic [31:0]       data  [NSETS];
  logic [29:0]       miss_word;

  logic [IDX_W-1:0]  req_idx, fill_idx;
  logic [TAG_W-1:0]  req_tag, fill_tag;
  logic              hit, miss, fill;
  logic              unused_addr_bits;

  assign req_idx  = bus.imemaddr[IDX_W+1:2];
  assign req_tag  = bus.imemaddr[31:IDX_W+2];
  assign fill_idx = miss_word[IDX_W-1:0];
  assign fill_tag = miss_word[29:IDX_W];
  assign unused_addr_bits = ^bus.imemaddr[1:0];

  always_comb begin
    next_state   = state;
    hit          = 1'b0;
    miss         = 1'b0;
    fill         = 1'b0;
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    case (state)
      IDLE: begin
        hit      = bus.imemREN && valid[req_idx] && (tags[req_idx] == req_tag);
        miss     = bus.imemREN && !hit;
        bus.ihit = hit;
        if (hit) bus.imemload = data[req_idx];
        if (miss) next_state = FETCH;
      end
      FETCH: begin
        // The fill is bound to the latched miss address, not the live request.
        bus.iREN  = 1'b1;
        bus.iaddr = {miss_word, 2'b00};
        if (!bus.iwait) begin
          fill       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < NSETS; i++) begin
        valid[i] <= 1'b0;
        tags[i]  <= '0;
        data[i]  <= '0;
      end
      miss_word  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (fill) begin
        valid[fill_idx] <= 1'b1;
        tags[fill_idx]  <= fill_tag;
        data[fill_idx]  <= bus.iload;
      end
      if (miss) begin
        miss_word  <= bus.imemaddr[31:2];
        miss_count <= miss_count + 32'd1;
      end
      if (hit) hit_count <= hit_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: reset, cold miss, conflict eviction, slow memory,
// retargeting during fill and reset during fill.
module tb_icache;
  logic        CLK;
  logic        nRST;
  logic [31:0] hit_count, miss_count;
  int          errors = 0;
  int          checks = 0;

  icache_if bus();

  icache #(.NSETS(16), .IDX_W(4)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    @(negedge CLK);
    nRST = 1'b0;
    bus.imemREN = 1'b0;
    bus.imemaddr = '0;
    bus.iwait = 1'b0;
    bus.iload = 32'hDEADBEEF;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // Miss then immediate fill; returns at the negedge of the first IDLE cycle after the fill.
  task automatic miss_fill(input logic [31:0] a, input logic [31:0] w);
    @(negedge CLK);
    bus.imemREN = 1'b1;
    bus.imemaddr = a;
    bus.iwait = 1'b0;
    bus.iload = w;
    @(negedge CLK);
    @(negedge CLK);
    bus.iload = 32'hDEADBEEF;
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    bus.imemREN = 1'b1;
    bus.imemaddr = 32'h0;
    bus.iwait = 1'b1;
    bus.iload = 32'hDEADBEEF;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit: got %b want 0", bus.ihit); end
    checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL reset_iREN: got %b want 0", bus.iREN); end
    checks++; if (bus.iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr: got %h want 0", bus.iaddr); end
    checks++; if (bus.imemload !== 32'h0) begin errors++; $display("FAIL reset_imemload: got %h want 0", bus.imemload); end
    checks++; if (hit_count !== 32'h0) begin errors++; $display("FAIL reset_hit_count: got %0d want 0", hit_count); end
    checks++; if (miss_count !== 32'h0) begin errors++; $display("FAIL reset_miss_count: got %0d want 0", miss_count); end
    nRST = 1'b1;
    #1;
    checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL post_reset_miss: got ihit=%b want 0", bus.ihit); end
    @(negedge CLK); #1;
    checks++; if (bus.iREN !== 1'b1) begin errors++; $display("FAIL post_reset_fetch_iREN: got %b want 1", bus.iREN); end
    checks++; if (bus.iaddr !== 32'h0) begin errors++; $display("FAIL post_reset_fetch_iaddr: got %h want 0", bus.iaddr); end
    checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL post_reset_miss_count: got %0d want 1", miss_count); end
  endtask

  task automatic test_cold_miss;
    do_reset();
    @(negedge CLK);
    bus.imemREN = 1'b1;
    bus.imemaddr = 32'h4;
    bus.iwait = 1'b0;
    bus.iload = 32'h8C220000;
    #1;
    checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL cold_c0_ihit: got %b want 0", bus.ihit); end
    @(negedge CLK); #1;
    checks++; if ({bus.iREN, bus.iaddr} !== {1'b1, 32'h4}) begin errors++; $display("FAIL cold_c1_fetch: got iREN=%b iaddr=%h want 1 00000004", bus.iREN, bus.iaddr); end
    checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL cold_c1_ihit: got %b want 0", bus.ihit); end
    @(negedge CLK); #1;
    bus.iload = 32'hDEADBEEF;
    #1;
    checks++; if ({bus.ihit, bus.imemload} !== {1'b1, 32'h8C220000}) begin errors++; $display("FAIL cold_c2_hit: got ihit=%b load=%h want 1 8c220000", bus.ihit, bus.imemload); end
    checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL cold_miss_count: got %0d want 1", miss_count); end
    checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL cold_c2_iREN: got %b want 0", bus.iREN); end
    repeat (4) @(negedge CLK);
    #1;
    checks++; if (hit_count !== 32'd4) begin errors++; $display("FAIL cold_hit_count: got %0d want 4", hit_count); end
    bus.imemREN = 1'b0;
    #1;
    checks++; if ({bus.ihit, bus.imemload} !== 33'h0) begin errors++; $display("FAIL cold_noreq_out: got ihit=%b load=%h want 0 0", bus.ihit, bus.imemload); end
    @(negedge CLK); #1;
    checks++; if ({hit_count, miss_count} !== {32'd4, 32'd1}) begin errors++; $display("FAIL cold_noreq_counts: got hit=%0d miss=%0d want 4 1", hit_count, miss_count); end
    checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL cold_noreq_iREN: got %b want 0", bus.iREN); end
  endtask

  task automatic test_conflict;
    do_reset();
    miss_fill(32'h0, 32'hAAAA0000);
    #1;
    checks++; if ({bus.ihit, bus.imemload} !== {1'b1, 32'hAAAA0000}) begin errors++; $display("FAIL conflict_a_hit: got ihit=%b load=%h want 1 aaaa0000", bus.ihit, bus.imemload); end
    miss_fill(32'h40, 32'hBBBB0040);
    #1;
    checks++; if ({bus.ihit, bus.imemload} !== {1'b1, 32'hBBBB0040}) begin errors++; $display("FAIL conflict_b_hit: got ihit=%b load=%h want 1 bbbb0040", bus.ihit, bus.imemload); end
    bus.imemaddr = 32'h0;
    #1;
    checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL conflict_a_evicted: got ihit=%b want 0", bus.ihit); end
    bus.iload = 32'hAAAA0000;
    @(negedge CLK); #1;
    checks++; if (miss_count !== 32'd3) begin errors++; $display("FAIL conflict_miss_count: got %0d want 3", miss_count); end
    checks++; if ({bus.iREN, bus.iaddr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL conflict_refetch: got iREN=%b iaddr=%h want 1 00000000", bus.iREN, bus.iaddr); end
    @(negedge CLK); #1;
    checks++; if ({bus.ihit, bus.imemload} !== {1'b1, 32'hAAAA0000}) begin errors++; $display("FAIL conflict_a_refill: got ihit=%b load=%h want 1 aaaa0000", bus.ihit, bus.imemload); end
  endtask

  task automatic test_slow_memory;
    do_reset();
    @(negedge CLK);
    bus.imemREN = 1'b1;
    bus.imemaddr = 32'h100;
    bus.iwait = 1'b1;
    bus.iload = 32'hDEADBEEF;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK); #1;
      checks++; if ({bus.iREN, bus.iaddr, bus.ihit} !== {1'b1, 32'h100, 1'b0}) begin
        errors++; $display("FAIL slow_wait%0d: got iREN=%b iaddr=%h ihit=%b want 1 00000100 0", k, bus.iREN, bus.iaddr, bus.ihit);
      end
      if (k == 2) bus.imemREN = 1'b0;
    end
    @(negedge CLK);
    bus.iwait = 1'b0;
    bus.iload = 32'h12345678;
    #1;
    checks++; if ({bus.iREN, bus.iaddr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL slow_last_fetch: got iREN=%b iaddr=%h want 1 00000100", bus.iREN, bus.iaddr); end
    @(negedge CLK);
    bus.iload = 32'hDEADBEEF;
    bus.imemREN = 1'b1;
    #1;
    checks++; if ({bus.ihit, bus.imemload} !== {1'b1, 32'h12345678}) begin errors++; $display("FAIL slow_hit: got ihit=%b load=%h want 1 12345678", bus.ihit, bus.imemload); end
    checks++; if ({bus.iREN, miss_count} !== {1'b0, 32'd1}) begin errors++; $display("FAIL slow_idle: got iREN=%b miss=%0d want 0 1", bus.iREN, miss_count); end
  endtask

  task automatic test_retarget;
    do_reset();
    @(negedge CLK);
    bus.imemREN = 1'b1;
    bus.imemaddr = 32'h200;
    bus.iwait = 1'b1;
    @(negedge CLK); #1;
    checks++; if (bus.iaddr !== 32'h200) begin errors++; $display("FAIL retarget_iaddr0: got %h want 00000200", bus.iaddr); end
    bus.imemaddr = 32'h300;
    @(negedge CLK);
    bus.iwait = 1'b0;
    bus.iload = 32'hA200A200;
    #1;
    checks++; if ({bus.iREN, bus.iaddr} !== {1'b1, 32'h200}) begin errors++; $display("FAIL retarget_iaddr1: got iREN=%b iaddr=%h want 1 00000200", bus.iREN, bus.iaddr); end
    @(negedge CLK);
    bus.iload = 32'hA300A300;
    #1;
    checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL retarget_300_miss: got ihit=%b want 0", bus.ihit); end
    bus.imemaddr = 32'h200;
    #1;
    checks++; if ({bus.ihit, bus.imemload} !== {1'b1, 32'hA200A200}) begin errors++; $display("FAIL retarget_200_hit: got ihit=%b load=%h want 1 a200a200", bus.ihit, bus.imemload); end
    bus.imemaddr = 32'h300;
    @(negedge CLK); #1;
    checks++; if ({bus.iREN, bus.iaddr, miss_count} !== {1'b1, 32'h300, 32'd2}) begin errors++; $display("FAIL retarget_300_fetch: got iREN=%b iaddr=%h miss=%0d want 1 00000300 2", bus.iREN, bus.iaddr, miss_count); end
    @(negedge CLK); #1;
    checks++; if ({bus.ihit, bus.imemload} !== {1'b1, 32'hA300A300}) begin errors++; $display("FAIL retarget_300_hit: got ihit=%b load=%h want 1 a300a300", bus.ihit, bus.imemload); end
  endtask

  task automatic test_reset_mid_fetch;
    do_reset();
    miss_fill(32'h4, 32'h44444444);
    @(negedge CLK); #1;
    checks++; if (hit_count !== 32'd1) begin errors++; $display("FAIL rmf_hit_count: got %0d want 1", hit_count); end
    bus.imemaddr = 32'h80;
    bus.iwait = 1'b1;
    @(negedge CLK); #1;
    checks++; if ({bus.iREN, bus.iaddr, miss_count} !== {1'b1, 32'h80, 32'd2}) begin errors++; $display("FAIL rmf_fetch: got iREN=%b iaddr=%h miss=%0d want 1 00000080 2", bus.iREN, bus.iaddr, miss_count); end
    nRST = 1'b0;
    #1;
    checks++; if ({bus.iREN, bus.iaddr} !== {1'b0, 32'h0}) begin errors++; $display("FAIL rmf_iREN_drop: got iREN=%b iaddr=%h want 0 0", bus.iREN, bus.iaddr); end
    checks++; if ({hit_count, miss_count} !== 64'h0) begin errors++; $display("FAIL rmf_counters: got hit=%0d miss=%0d want 0 0", hit_count, miss_count); end
    bus.iwait = 1'b0;
    bus.iload = 32'h80808080;
    @(negedge CLK);
    nRST = 1'b1;
    bus.iwait = 1'b1;
    #1;
    checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL rmf_80_miss: got ihit=%b want 0", bus.ihit); end
    bus.imemaddr = 32'h4;
    #1;
    checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL rmf_4_invalid: got ihit=%b want 0", bus.ihit); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_slow_memory();
    test_retarget();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
